// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM sequencing the multi-cycle MIPS datapath
module mips_multicycle_control #(
  parameter int ENABLE_ADDI = 1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB
  } state_t;
  state_t state, nxt;
  logic done_n, ill_n;
  assign dbg_state = state;
  // next state plus the retire/illegal events that become next cycle's pulses
  always_comb begin
    nxt = FETCH;
    done_n = 1'b0;
    ill_n = 1'b0;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        nxt = opcode == OP_R ? EXEC :
              (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
              opcode == OP_BEQ ? BRANCH :
              opcode == OP_J ? JUMP :
              (opcode == OP_ADDI && ENABLE_ADDI != 0) ? ADDIEX : FETCH;
        ill_n = nxt == FETCH;
      end
      MEMADR: nxt = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  begin nxt = mem_ready ? FETCH : MEMWR; done_n = mem_ready; end
      EXEC:   nxt = RWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, RWB, BRANCH, JUMP, ADDIWB: done_n = 1'b1;
      default: nxt = FETCH;
    endcase
  end
  // state register and registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state <= nxt;
      instr_done <= done_n;
      illegal_op <= ill_n;
    end
  end
  // Moore control decode; reset blanks everything so an aborted instruction writes nothing
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite = 1'b0;
    PCSource = 2'b00;
    ALUOp = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    RegWrite = 1'b0;
    RegDst = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:  begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = mem_ready; PCWrite = mem_ready; end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
        EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        RWB:    begin RegWrite = 1'b1; RegDst = 1'b1; end
        BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; end
        JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
        ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed scoreboard bench for the multi-cycle control FSM
module tb_mips_multicycle_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
  logic clk = 1'b0, rst, mem_ready;
  logic [5:0] opcode;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic instr_done, illegal_op;
  logic [3:0] dbg_state;
  logic z_pcw, z_pwc, z_iord, z_mrd, z_mw, z_m2r, z_irw, z_srca, z_rw, z_rd, z_done, z_ill;
  logic [1:0] z_psrc, z_aop, z_srcb;
  logic [3:0] z_state;
  int checks = 0, failures = 0, stp = 0;
  typedef struct { int st; logic [15:0] ctl; logic dn; logic il; } exp_t;
  exp_t q[$];
  logic [15:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegDst(RegDst),
    .instr_done(instr_done), .illegal_op(illegal_op), .dbg_state(dbg_state));

  mips_multicycle_control #(.ENABLE_ADDI(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(z_pcw), .PCWriteCond(z_pwc), .IorD(z_iord), .MemRead(z_mrd),
    .MemWrite(z_mw), .MemtoReg(z_m2r), .IRWrite(z_irw), .PCSource(z_psrc),
    .ALUOp(z_aop), .ALUSrcA(z_srca), .ALUSrcB(z_srcb), .RegWrite(z_rw), .RegDst(z_rd),
    .instr_done(z_done), .illegal_op(z_ill), .dbg_state(z_state));

  function automatic logic [15:0] exp_ctrl(input int s, input logic mr, input logic r);
    logic pcw = 0, pwc = 0, iord = 0, mrd = 0, mw = 0, m2r = 0, irw = 0, srca = 0, rw = 0, rd = 0;
    logic [1:0] psrc = 0, aop = 0, srcb = 0;
    if (!r)
      case (s)
        0:  begin pcw = mr; irw = mr; mrd = 1; srcb = 2'b01; end
        1:  srcb = 2'b11;
        2:  begin srca = 1; srcb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin rw = 1; m2r = 1; end
        5:  begin mw = 1; iord = 1; end
        6:  begin srca = 1; aop = 2'b10; end
        7:  begin rw = 1; rd = 1; end
        8:  begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
        9:  begin pcw = 1; psrc = 2'b10; end
        10: begin srca = 1; srcb = 2'b10; end
        11: rw = 1;
        default: ;
      endcase
    return {pcw, pwc, iord, mrd, mw, m2r, irw, psrc, aop, srca, srcb, rw, rd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL step%0d %s observed=%0h expected=%0h", stp, tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input int es, input logic ed, input logic ei);
    exp_t e;
    @(posedge clk); #1;
    stp++;
    rst = r; opcode = op; mem_ready = mr;
    q.push_back('{es, exp_ctrl(es, mr, r), ed, ei});
    @(negedge clk);
    e = q.pop_front();
    chk("state", 32'(dbg_state), 32'(e.st));
    chk("ctrl", 32'(ctl), 32'(e.ctl));
    chk("instr_done", 32'(instr_done), 32'(e.dn));
    chk("illegal_op", 32'(illegal_op), 32'(e.il));
  endtask

  initial begin
    rst = 1; opcode = R; mem_ready = 0;
    repeat (2) @(posedge clk);
    step(1, R, 1, 0, 0, 0);
    step(0, R, 1, 0, 0, 0);
    step(0, R, 1, 1, 0, 0);
    step(0, R, 1, 6, 0, 0);
    step(0, R, 1, 7, 0, 0);
    step(0, LW, 1, 0, 1, 0);
    step(0, LW, 0, 1, 0, 0);
    step(0, LW, 1, 2, 0, 0);
    step(0, LW, 0, 3, 0, 0);
    step(0, LW, 0, 3, 0, 0);
    step(0, LW, 1, 3, 0, 0);
    step(0, LW, 0, 4, 0, 0);
    step(0, BEQ, 0, 0, 1, 0);
    step(0, BEQ, 0, 0, 0, 0);
    step(0, BEQ, 0, 0, 0, 0);
    step(0, BEQ, 1, 0, 0, 0);
    step(0, BEQ, 1, 1, 0, 0);
    step(0, BEQ, 1, 8, 0, 0);
    step(0, J, 1, 0, 1, 0);
    step(0, J, 1, 1, 0, 0);
    step(0, J, 1, 9, 0, 0);
    step(0, BAD, 1, 0, 1, 0);
    step(0, BAD, 1, 1, 0, 0);
    step(0, ADDI, 1, 0, 0, 1);
    step(0, ADDI, 1, 1, 0, 0);
    step(0, ADDI, 1, 10, 0, 0);
    chk("noaddi_state", 32'(z_state), 32'd0);
    chk("noaddi_illegal", 32'(z_ill), 32'd1);
    chk("noaddi_writes", 32'({z_rw, z_mw}), 32'd0);
    step(0, ADDI, 1, 11, 0, 0);
    chk("noaddi_state2", 32'(z_state), 32'd1);
    chk("noaddi_illegal2", 32'(z_ill), 32'd0);
    step(0, SW, 1, 0, 1, 0);
    step(0, SW, 0, 1, 0, 0);
    step(0, SW, 0, 2, 0, 0);
    step(0, SW, 0, 5, 0, 0);
    step(0, SW, 1, 5, 0, 0);
    step(0, SW, 1, 0, 1, 0);
    step(0, SW, 0, 1, 0, 0);
    step(0, SW, 0, 2, 0, 0);
    step(0, SW, 0, 5, 0, 0);
    step(1, SW, 0, 5, 0, 0);
    step(0, SW, 0, 0, 0, 0);
    step(0, R, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath. Sits directly upstream of the ALU control stage: it decodes the IR opcode, sequences each instruction through fetch/decode/execute/memory/writeback, and drives ALUOp[1:0] into the ALU control block plus all datapath enables and muxes.
- A mem_ready handshake lets a slow memory stretch the memory-access states.

Parameters:
- ENABLE_ADDI, 1, when 1 the addi opcode is decoded; when 0 addi is treated as illegal.
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  out  2  to ALU control: 00 = add, 01 = sub, 10 = use funct.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- RegWrite  out  1  register file write.
- RegDst  out  1  destination select: 0 = rt, 1 = rd.
- instr_done  out  1  registered one-cycle pulse when an instruction retires.
- illegal_op  out  1  registered one-cycle pulse on an undecodable opcode.
- dbg_state  out  STATE_W  current state encoding.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: state <= FETCH (0); instr_done and illegal_op <= 0. While rst = 1, every control output is forced to 0, including during a mid-instruction reset, so an aborted instruction performs no writes.
- Outputs are Moore, decoded from state. Any control output not listed for a state is 0.
- FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite equal mem_ready. This is the only Mealy gating.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE (1): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX (only if ENABLE_ADDI = 1)
  - anything else -> FETCH, with illegal_op = 1 in the following cycle.
- MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next is MEMRD for lw, MEMWR for sw. The opcode is re-sampled here; IR is stable because IRWrite = 0.
- MEMRD (3): MemRead = 1, IorD = 1. Hold while mem_ready = 0, then go to MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. Then FETCH.
- MEMWR (5): MemWrite = 1, IorD = 1. Hold while mem_ready = 0, then FETCH. MemWrite stays high throughout the hold.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Then RWB.
- RWB (7): RegWrite = 1, RegDst = 1, MemtoReg = 0. Then FETCH.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Then FETCH.
- JUMP (9): PCWrite = 1, PCSource = 10. Then FETCH.
- ADDIEX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Then ADDIWB.
- ADDIWB (11): RegWrite = 1, RegDst = 0, MemtoReg = 0. Then FETCH.
- Encodings 12-15 are unreachable. If entered, go to FETCH next cycle with all outputs 0 and no pulses.
- instr_done is asserted in the cycle after leaving MEMWB, MEMWR (on mem_ready), RWB, BRANCH, JUMP or ADDIWB. It is never asserted for an illegal opcode.
- ALUOp = 11 is never generated.
- If mem_ready is asserted outside FETCH, MEMRD or MEMWR, it is ignored.

Test Plan:
- rst high 2 cycles, then R-type opcode with mem_ready = 1 -> states 0,1,6,7,0. ALUOp = 10 in EXEC only; RegWrite = 1, RegDst = 1 in RWB; instr_done high on cycle 5.
- lw (100011) with mem_ready low for 2 cycles during MEMRD -> states 0,1,2,3,3,3,4,0. MemRead/IorD held 3 cycles; MemtoReg = 1 and RegWrite = 1 for exactly 1 cycle.
- Fetch stall: mem_ready = 0 for 3 cycles, then 1 -> IRWrite/PCWrite pulse once, on the 4th FETCH cycle only.
- beq (000100) then j (000010) -> 3 cycles each. BRANCH: PCWriteCond = 1, ALUOp = 01, PCSource = 01. JUMP: PCWrite = 1, PCSource = 10.
- Opcode 111111 -> DECODE then FETCH, illegal_op = 1 for one cycle, no RegWrite/MemWrite. Same for addi with ENABLE_ADDI = 0; with ENABLE_ADDI = 1, addi sequences 0,1,10,11.
- rst asserted during MEMWR with mem_ready = 0 -> MemWrite = 0 in the reset cycle, FETCH next cycle, no instr_done.
